// File: rtl/video_frame_path_sel.sv
// Frame-locked 2:1 AXI4-Stream selector with one output register slice (1-cycle latency).
// Path switches only at frame ends; optional macro VIDEO_FRAME_PATH_SEL_DROP_UNSEL_EN drains the idle input.
module video_frame_path_sel #(
  parameter int TDATA_WIDTH = 32,
  parameter int LINES_WIDTH = 12,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   sel_i,
  input  logic [LINES_WIDTH-1:0] frame_lines_i,
  input  logic                   a_tvalid,
  input  logic [TDATA_WIDTH-1:0] a_tdata,
  input  logic                   a_tlast,
  input  logic                   a_tuser,
  output logic                   a_tready,
  input  logic                   b_tvalid,
  input  logic [TDATA_WIDTH-1:0] b_tdata,
  input  logic                   b_tlast,
  input  logic                   b_tuser,
  output logic                   b_tready,
  output logic                   o_tvalid,
  output logic [TDATA_WIDTH-1:0] o_tdata,
  output logic                   o_tlast,
  output logic                   o_tuser,
  input  logic                   o_tready,
  output logic                   active_sel_o,
  output logic [CNT_WIDTH-1:0]   frame_cnt_o,
  output logic [CNT_WIDTH-1:0]   resync_cnt_o
);

  typedef enum logic {SYNC = 1'b0, PASS = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic                   init_q;
  logic                   active_sel_q, active_sel_d;
  logic [LINES_WIDTH-1:0] lines_m1_q, lines_m1_d;
  logic [LINES_WIDTH-1:0] line_cnt_q, line_cnt_d;
  logic [CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
  logic [CNT_WIDTH-1:0]   resync_cnt_q, resync_cnt_d;
  logic                   o_vld_q;
  logic [TDATA_WIDTH-1:0] o_dat_q;
  logic                   o_last_q, o_user_q;

  logic                   s_vld, s_last, s_user;
  logic [TDATA_WIDTH-1:0] s_dat;
  logic                   slice_free, sel_rdy, unsel_rdy, load, frame_end;
  logic [LINES_WIDTH-1:0] lines_m1_in;

  assign s_vld  = active_sel_q ? b_tvalid : a_tvalid;
  assign s_dat  = active_sel_q ? b_tdata  : a_tdata;
  assign s_last = active_sel_q ? b_tlast  : a_tlast;
  assign s_user = active_sel_q ? b_tuser  : a_tuser;

  assign slice_free  = !o_vld_q || o_tready;
  // A programmed line count of zero behaves as a single-line frame.
  assign lines_m1_in = (frame_lines_i == '0) ? '0 : frame_lines_i - LINES_WIDTH'(1);

`ifdef VIDEO_FRAME_PATH_SEL_DROP_UNSEL_EN
  assign unsel_rdy = !init_q;
`else
  assign unsel_rdy = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    active_sel_d = active_sel_q;
    lines_m1_d   = lines_m1_q;
    line_cnt_d   = line_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    resync_cnt_d = resync_cnt_q;
    sel_rdy      = 1'b0;
    load         = 1'b0;
    frame_end    = 1'b0;

    if (init_q) begin
      // First cycle out of reset behaves as SYNC entry.
      active_sel_d = sel_i;
      lines_m1_d   = lines_m1_in;
    end else begin
      case (state_q)
        SYNC: begin
          // Non-SOF beats are always dropped; an SOF must wait for a free slice.
          sel_rdy = !s_user || slice_free;
          if (s_vld && sel_rdy && s_user) begin
            load       = 1'b1;
            line_cnt_d = '0;
            if (s_last && (lines_m1_q == '0)) frame_end = 1'b1;
            else                               state_d   = PASS;
          end
        end
        PASS: begin
          sel_rdy = slice_free;
          if (s_vld && sel_rdy) begin
            load = 1'b1;
            if (s_user) begin
              if (resync_cnt_q != '1) resync_cnt_d = resync_cnt_q + CNT_WIDTH'(1);
              line_cnt_d = s_last ? LINES_WIDTH'(1) : '0;
            end else if (s_last) begin
              if (line_cnt_q >= lines_m1_q) frame_end = 1'b1;
              else                          line_cnt_d = line_cnt_q + LINES_WIDTH'(1);
            end
          end
        end
        default: state_d = SYNC;
      endcase
    end

    if (frame_end) begin
      state_d      = SYNC;
      frame_cnt_d  = frame_cnt_q + CNT_WIDTH'(1);
      active_sel_d = sel_i;
      lines_m1_d   = lines_m1_in;
      line_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= SYNC;
      init_q       <= 1'b1;
      active_sel_q <= 1'b0;
      lines_m1_q   <= '0;
      line_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      resync_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      init_q       <= 1'b0;
      active_sel_q <= active_sel_d;
      lines_m1_q   <= lines_m1_d;
      line_cnt_q   <= line_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      resync_cnt_q <= resync_cnt_d;
    end
  end

  // Output register slice: holds while stalled, empties only on a handshake with no refill.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      o_vld_q  <= 1'b0;
      o_dat_q  <= '0;
      o_last_q <= 1'b0;
      o_user_q <= 1'b0;
    end else if (load) begin
      o_vld_q  <= 1'b1;
      o_dat_q  <= s_dat;
      o_last_q <= s_last;
      o_user_q <= s_user;
    end else if (o_tready) begin
      o_vld_q  <= 1'b0;
    end
  end

  assign a_tready     = active_sel_q ? unsel_rdy : sel_rdy;
  assign b_tready     = active_sel_q ? sel_rdy   : unsel_rdy;
  assign o_tvalid     = o_vld_q;
  assign o_tdata      = o_dat_q;
  assign o_tlast      = o_last_q;
  assign o_tuser      = o_user_q;
  assign active_sel_o = active_sel_q;
  assign frame_cnt_o  = frame_cnt_q;
  assign resync_cnt_o = resync_cnt_q;

endmodule
